sine_seq_ctrl: RTL and testbench

SINE_SEQ_CTRL -- requirements
Module: sine_seq_ctrl

---
 rtl/sine_seq_ctrl.sv | 172 +++++++++++++++++
 tb/tb_sine_seq_ctrl.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sine_seq_ctrl.sv
`default_nettype none
// ==========================================================================
// sine_seq_ctrl : sine ROM address sequencer with a ROM-latency-matched valid pipeline.
// Optional start phase offset port when SINE_SEQ_OFFSET_EN is defined.  Rev 1.0
// ==========================================================================
module sine_seq_ctrl #(
   parameter int TABLE_DEPTH = 632,
   parameter int ADDR_W      = 10,
   parameter int DATA_W      = 13,
   parameter int ROM_LAT     = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              i_start,
   input  logic              i_stop,
   input  logic [ADDR_W-1:0] iv_step,
   input  logic [15:0]       iv_period_num,
`ifdef SINE_SEQ_OFFSET_EN
   input  logic [ADDR_W-1:0] iv_phase_offset,
`endif
   output logic [ADDR_W-1:0] ov_address,
   input  logic [DATA_W-1:0] iv_rom_data,
   output logic [DATA_W-1:0] ov_data,
   output logic              o_data_valid,
   output logic              o_busy,
   output logic              o_done
);

   localparam int              FC_W       = $clog2(ROM_LAT + 2);
   localparam logic [ADDR_W:0] DEPTH_X    = (ADDR_W+1)'(TABLE_DEPTH);
   localparam logic [ADDR_W-1:0] STEP_MAX = ADDR_W'(TABLE_DEPTH - 1);
   localparam logic [FC_W-1:0] FLUSH_LAST = FC_W'(ROM_LAT);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_FLUSH = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   logic [1:0]        state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ADDR_W-1:0] step_q, step_d;
   logic [15:0]       per_num_q, per_num_d;
   logic [15:0]       per_cnt_q, per_cnt_d;
   logic [FC_W-1:0]   flush_cnt_q, flush_cnt_d;
   logic [ROM_LAT-1:0] vld_pipe_q;
   logic [DATA_W-1:0] data_q;
   logic              data_vld_q;

   logic [ADDR_W:0]   w_sum;
   logic              w_wrap;
   logic [15:0]       w_per_inc;
   logic              w_period_end;
   logic              w_run_end;
   logic              w_issue;
   logic [ADDR_W-1:0] w_step_sat;
   logic [ADDR_W-1:0] w_first_addr;

   // One extra bit keeps addr+step from overflowing before the wrap test.
   assign w_sum        = {1'b0, addr_q} + {1'b0, step_q};
   assign w_wrap       = (w_sum >= DEPTH_X);
   assign w_per_inc    = per_cnt_q + 16'd1;
   assign w_period_end = w_wrap && (per_num_q != 16'd0) && (w_per_inc == per_num_q);
   assign w_run_end    = i_stop || w_period_end;

   always_comb begin
      w_step_sat = iv_step;
      if (iv_step == '0) begin
         w_step_sat = ADDR_W'(1);
      end else if ({1'b0, iv_step} >= DEPTH_X) begin
         w_step_sat = STEP_MAX;
      end
   end

`ifdef SINE_SEQ_OFFSET_EN
   assign w_first_addr = ({1'b0, iv_phase_offset} >= DEPTH_X) ? '0 : iv_phase_offset;
`else
   assign w_first_addr = '0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (i_start) state_d = ST_RUN;
         ST_RUN:   if (w_run_end) state_d = ST_FLUSH;
         ST_FLUSH: if (flush_cnt_q == FLUSH_LAST) state_d = ST_DONE;
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      w_issue = 1'b0;
      o_busy  = 1'b0;
      o_done  = 1'b0;
      case (state_q)
         ST_RUN: begin
            w_issue = 1'b1;
            o_busy  = 1'b1;
         end
         ST_FLUSH: o_busy = 1'b1;
         ST_DONE:  o_done = 1'b1;
         default: ;
      endcase
   end

   // The address on the bus in a RUN cycle is always issued; a stop or the
   // final wrap only prevents the following address from being loaded.
   always_comb begin
      addr_d      = addr_q;
      step_d      = step_q;
      per_num_d   = per_num_q;
      per_cnt_d   = per_cnt_q;
      flush_cnt_d = '0;
      case (state_q)
         ST_IDLE: begin
            if (i_start) begin
               addr_d    = w_first_addr;
               step_d    = w_step_sat;
               per_num_d = iv_period_num;
               per_cnt_d = '0;
            end
         end
         ST_RUN: begin
            if (w_wrap) per_cnt_d = w_per_inc;
            if (!w_run_end) begin
               addr_d = w_wrap ? ADDR_W'(w_sum - DEPTH_X) : w_sum[ADDR_W-1:0];
            end
         end
         ST_FLUSH: flush_cnt_d = flush_cnt_q + FC_W'(1);
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         addr_q      <= '0;
         step_q      <= '0;
         per_num_q   <= '0;
         per_cnt_q   <= '0;
         flush_cnt_q <= '0;
         vld_pipe_q  <= '0;
         data_q      <= '0;
         data_vld_q  <= 1'b0;
      end else begin
         addr_q        <= addr_d;
         step_q        <= step_d;
         per_num_q     <= per_num_d;
         per_cnt_q     <= per_cnt_d;
         flush_cnt_q   <= flush_cnt_d;
         vld_pipe_q[0] <= w_issue;
         for (int i = 1; i < ROM_LAT; i++) begin
            vld_pipe_q[i] <= vld_pipe_q[i-1];
         end
         data_vld_q <= vld_pipe_q[ROM_LAT-1];
         if (vld_pipe_q[ROM_LAT-1]) data_q <= iv_rom_data;
      end
   end

   assign ov_address   = addr_q;
   assign ov_data      = data_q;
   assign o_data_valid = data_vld_q;

endmodule
`default_nettype wire

// File: tb/tb_sine_seq_ctrl.sv
`default_nettype none
// tb_sine_seq_ctrl : directed and randomized runs checked every cycle against
// a timeline model built from the expected address list of each run.
module tb_sine_seq_ctrl;
   localparam int DEPTH = 632;
   localparam int AW    = 10;
   localparam int DW    = 13;
   localparam int LAT   = 2;
   localparam int CAP   = 4000;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          i_start = 1'b0;
   logic          i_stop = 1'b0;
   logic [AW-1:0] iv_step = '0;
   logic [15:0]   iv_period_num = '0;
   logic [AW-1:0] ov_address;
   logic [DW-1:0] iv_rom_data;
   logic [DW-1:0] ov_data;
   logic          o_data_valid;
   logic          o_busy;
   logic          o_done;
`ifdef SINE_SEQ_OFFSET_EN
   logic [AW-1:0] iv_phase_offset = '0;
`endif

   logic [DW-1:0] rom [0:1023];
   logic [AW-1:0] apipe [LAT];

   int n_checks = 0;
   int n_err    = 0;
   int cyc      = 0;
   bit chk_en   = 1'b0;

   // reference model state
   int            m_list[$];
   bit            m_active = 1'b0;
   int            m_start  = 0;
   int            m_n      = 0;
   int            m_rel    = 0;
   int            m_first  = 0;
   logic [AW-1:0] m_addr = '0;
   logic [DW-1:0] m_data = '0;
   bit            e_busy, e_done, e_valid;
   int            dut_valid_cnt = 0;
   int            dut_done_cnt  = 0;

   always #5 clk = ~clk;

   sine_seq_ctrl #(
      .TABLE_DEPTH(DEPTH),
      .ADDR_W     (AW),
      .DATA_W     (DW),
      .ROM_LAT    (LAT)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .i_start        (i_start),
      .i_stop         (i_stop),
      .iv_step        (iv_step),
      .iv_period_num  (iv_period_num),
`ifdef SINE_SEQ_OFFSET_EN
      .iv_phase_offset(iv_phase_offset),
`endif
      .ov_address     (ov_address),
      .iv_rom_data    (iv_rom_data),
      .ov_data        (ov_data),
      .o_data_valid   (o_data_valid),
      .o_busy         (o_busy),
      .o_done         (o_done)
   );

   // ROM with LAT cycles of address-to-data latency
   always @(posedge clk) begin
      apipe[0] <= ov_address;
      for (int i = 1; i < LAT; i++) apipe[i] <= apipe[i-1];
   end
   assign iv_rom_data = rom[apipe[LAT-1]];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
      end
   endtask

   // Expected issued addresses of one run, straight from the stepping rules.
   task automatic build(input int step_raw, input int pnum, input int first);
      int s, a, wraps;
      s = (step_raw == 0) ? 1 : ((step_raw >= DEPTH) ? DEPTH - 1 : step_raw);
      a = first;
      wraps = 0;
      m_list.delete();
      while (m_list.size() < CAP) begin
         m_list.push_back(a);
         a = a + s;
         if (a >= DEPTH) begin
            a = a - DEPTH;
            wraps++;
            if (pnum != 0 && wraps == pnum) break;
         end
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         e_busy  = 1'b0;
         e_done  = 1'b0;
         e_valid = 1'b0;
         if (m_active) begin
            m_rel = cyc - m_start;
            if (m_rel > m_n + LAT + 2) begin
               m_active = 1'b0;
            end else begin
               if (m_rel >= 1 && m_rel <= m_n) m_addr = AW'(m_list[m_rel-1]);
               if (m_rel >= LAT + 2 && m_rel <= m_n + LAT + 1) begin
                  e_valid = 1'b1;
                  m_data  = rom[m_list[m_rel-LAT-2]];
               end
               e_busy = (m_rel >= 1) && (m_rel <= m_n + LAT + 1);
               e_done = (m_rel == m_n + LAT + 2);
            end
         end
         chk("busy", {31'd0, o_busy}, {31'd0, e_busy});
         chk("done", {31'd0, o_done}, {31'd0, e_done});
         chk("valid", {31'd0, o_data_valid}, {31'd0, e_valid});
         chk("address", 32'(ov_address), 32'(m_addr));
         chk("data", 32'(ov_data), 32'(m_data));
         if (o_data_valid === 1'b1) dut_valid_cnt++;
         if (o_done === 1'b1) dut_done_cnt++;

         if (reset) begin
            m_active = 1'b0;
            m_addr   = '0;
            m_data   = '0;
         end else if (m_active && m_rel >= 1 && m_rel <= m_n) begin
            if (i_stop) m_n = m_rel;
         end else if (!m_active && i_start) begin
`ifdef SINE_SEQ_OFFSET_EN
            m_first = (int'(iv_phase_offset) >= DEPTH) ? 0 : int'(iv_phase_offset);
`else
            m_first = 0;
`endif
            build(int'(iv_step), int'(iv_period_num), m_first);
            m_n      = m_list.size();
            m_start  = cyc;
            m_active = 1'b1;
         end
      end
   end

   task automatic do_run(input int step, input int pnum, input int off, input int stop_after,
                         input bit both, input bit poke);
      int k;
      dut_valid_cnt = 0;
      dut_done_cnt  = 0;
      @(posedge clk); #1;
      i_stop = 1'b1;
      @(posedge clk); #1;
      i_stop        = both;
      i_start       = 1'b1;
      iv_step       = AW'(step);
      iv_period_num = 16'(pnum);
`ifdef SINE_SEQ_OFFSET_EN
      iv_phase_offset = AW'(off);
`endif
      for (k = 1; k < 5000; k++) begin
         @(posedge clk); #1;
         i_start       = poke && (k == 3);
         i_stop        = (stop_after != 0) && (k == stop_after);
         iv_step       = AW'($urandom);
         iv_period_num = 16'($urandom);
`ifdef SINE_SEQ_OFFSET_EN
         iv_phase_offset = AW'($urandom);
`endif
         if (k > 1 && !m_active) break;
      end
      i_start = 1'b0;
      i_stop  = 1'b0;
      if (k >= 5000) begin
         n_checks++;
         n_err++;
         $display("FAIL run_timeout: step=%0d pnum=%0d still active after %0d cycles", step, pnum, k);
      end
   endtask

   initial begin
      int st, pn, sa;
      for (int i = 0; i < 1024; i++) rom[i] = DW'($urandom);
      for (int i = 0; i < LAT; i++) apipe[i] = '0;
      reset = 1'b1;
      @(posedge clk); #1;
      chk_en = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;

      // step 1, one period: 0..631 once
      do_run(1, 1, 0, 0, 1'b0, 1'b0);
      chk("s1_valid_count", 32'(dut_valid_cnt), 32'd632);
      chk("s1_done_count", 32'(dut_done_cnt), 32'd1);
      chk("s1_model_len", 32'(m_list.size()), 32'd632);
      chk("s1_model_last", 32'(m_list[631]), 32'd631);

      // step 5, two periods
      do_run(5, 2, 0, 0, 1'b0, 1'b0);
      chk("s5_valid_count", 32'(dut_valid_cnt), 32'd253);
      chk("s5_model_len", 32'(m_list.size()), 32'd253);
      chk("s5_model_wrap_prev", 32'(m_list[126]), 32'd630);
      chk("s5_model_wrap", 32'(m_list[127]), 32'd3);
      chk("s5_model_last", 32'(m_list[252]), 32'd628);

      // continuous, stopped 100 cycles after start
      do_run(1, 0, 0, 100, 1'b0, 1'b0);
      chk("stop_valid_count", 32'(dut_valid_cnt), 32'd100);
      chk("stop_done_count", 32'(dut_done_cnt), 32'd1);

      // step 0 acts as 1, extra start while busy ignored
      do_run(0, 1, 0, 0, 1'b0, 1'b1);
      chk("s0_valid_count", 32'(dut_valid_cnt), 32'd632);
      chk("s0_model_second", 32'(m_list[1]), 32'd1);

      // step 700 acts as 631
      do_run(700, 3, 0, 0, 1'b0, 1'b0);
      chk("s700_valid_count", 32'(dut_valid_cnt), 32'd4);
      chk("s700_model_last", 32'(m_list[3]), 32'd629);

      // start and stop together in IDLE: start wins
      do_run(3, 1, 0, 0, 1'b1, 1'b0);
      chk("both_valid_count", 32'(dut_valid_cnt), 32'd211);

      // reset in the middle of RUN
      dut_done_cnt = 0;
      @(posedge clk); #1;
      i_start = 1'b1; iv_step = AW'(3); iv_period_num = 16'd0;
      @(posedge clk); #1;
      i_start = 1'b0;
      repeat (49) @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      dut_valid_cnt = 0;
      repeat (8) @(posedge clk);
      #1;
      chk("reset_no_done", 32'(dut_done_cnt), 32'd0);
      chk("reset_no_valid", 32'(dut_valid_cnt), 32'd0);
      do_run(2, 1, 0, 0, 1'b0, 1'b0);
      chk("after_reset_valid_count", 32'(dut_valid_cnt), 32'd316);

`ifdef SINE_SEQ_OFFSET_EN
      do_run(1, 1, 316, 0, 1'b0, 1'b0);
      chk("off316_valid_count", 32'(dut_valid_cnt), 32'd316);
      chk("off316_model_first", 32'(m_list[0]), 32'd316);
      do_run(1, 1, 800, 0, 1'b0, 1'b0);
      chk("off800_valid_count", 32'(dut_valid_cnt), 32'd632);
      chk("off800_model_first", 32'(m_list[0]), 32'd0);
`endif

      for (int r = 0; r < 10; r++) begin
         st = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 1023)) : int'($urandom_range(0, 40));
         pn = int'($urandom_range(0, 3));
         if (pn == 0) sa = int'($urandom_range(1, 300));
         else sa = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 150)) : 0;
         do_run(st, pn, int'($urandom_range(0, 1023)), sa,
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         chk("rand_done_count", 32'(dut_done_cnt), 32'd1);
      end

      repeat (3) @(posedge clk);
      #1;
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
